// File: rtl/i2c_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// i2c_xfer_ctrl
// Sequencer that drives a memory-mapped I2C master controller (i2c_top_module)
// through its register port to perform whole read/write transactions.
//
// After reset it programs the frequency divider and enables the controller,
// then accepts one command at a time (address, direction, byte count) and
// steps through START / address / data bytes / STOP by writing CR and DR and
// polling SR for MIF.
//
// Ports
//   sysclk_i, reset_n_i        clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o  command handshake
//   cmd_addr_i[6:0]            slave address
//   cmd_rw_i                   1 = read, 0 = write
//   cmd_len_i[3:0]             data byte count (0 = address-only probe)
//   tx_data_i[7:0] / tx_req_o  write byte, consumed in the tx_req_o cycle
//   rx_data_o[7:0] / rx_valid_o received byte strobe
//   done_o / err_o / busy_o    end pulse, error (qualified by done_o), active
//   wr_ena_o, wr_addr_o, wr_data_o   controller register write port
//   rd_ena_o, rd_addr_o, rd_data_i   controller register read port
//                                    (rd_data_i valid one cycle after rd_ena_o)
// -----------------------------------------------------------------------------
module i2c_xfer_ctrl #(
   parameter logic [7:0]  FDR_VAL  = 8'h07,
   parameter int unsigned POLL_GAP = 4
) (
   input  logic       sysclk_i,
   input  logic       reset_n_i,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [6:0] cmd_addr_i,
   input  logic       cmd_rw_i,
   input  logic [3:0] cmd_len_i,
   input  logic [7:0] tx_data_i,
   output logic       tx_req_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       done_o,
   output logic       err_o,
   output logic       busy_o,
   output logic       wr_ena_o,
   output logic [4:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       rd_ena_o,
   output logic [4:0] rd_addr_o,
   input  logic [7:0] rd_data_i
);

   localparam logic [4:0] A_FDR = 5'h04;
   localparam logic [4:0] A_CR  = 5'h08;
   localparam logic [4:0] A_SR  = 5'h0C;
   localparam logic [4:0] A_DR  = 5'h10;

   localparam logic [7:0] CR_IDLE  = 8'h80;  // MEN only: also generates STOP
   localparam logic [7:0] CR_START = 8'hB0;  // MEN|MSTA|MTX
   localparam logic [7:0] CR_RX    = 8'hA0;  // MEN|MSTA
   localparam logic [7:0] CR_RXNAK = 8'hA8;  // MEN|MSTA|TXAK

   localparam logic [7:0] GAP = 8'(POLL_GAP);

   typedef enum logic [3:0] {
      S_INIT_FDR, S_INIT_CR, S_IDLE, S_START, S_ADDR, S_POLL, S_CHK,
      S_TXB, S_RXSET, S_RXDUMMY, S_RXB, S_STOP, S_FIN
   } state_t;

   // Which byte the pending MIF belongs to.
   typedef enum logic [1:0] {PH_ADDR, PH_TX, PH_RX} phase_t;

   state_t     state_q, state_d;
   phase_t     phase_q;
   logic [6:0] addr_q;
   logic       rw_q;
   logic [3:0] len_q;
   logic [3:0] cnt_q;
   logic       err_q;
   logic [7:0] gap_q;
   logic       chk2_q;     // second CHK cycle: CR update before reading DR
   logic       rx_pend_q;  // DR read issued last cycle, data arriving now

   logic sr_mif, sr_mal, sr_rxak;
   logic gap_done, last_rx, penult_rx;

   assign sr_mif  = rd_data_i[1];
   assign sr_mal  = rd_data_i[4];
   assign sr_rxak = rd_data_i[0];

   assign gap_done  = (gap_q == GAP);
   // 5-bit compares so that len=15 never wraps
   assign last_rx   = (({1'b0, cnt_q} + 5'd1) == {1'b0, len_q});
   assign penult_rx = (({1'b0, cnt_q} + 5'd2) == {1'b0, len_q});

   // State register
   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) state_q <= S_INIT_FDR;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT_FDR: state_d = S_INIT_CR;
         S_INIT_CR:  state_d = S_IDLE;
         S_IDLE:     if (cmd_valid_i) state_d = S_START;
         S_START:    state_d = S_ADDR;
         S_ADDR:     state_d = S_POLL;
         S_POLL:     if (gap_done) state_d = S_CHK;
         S_CHK: begin
            if (chk2_q)       state_d = S_RXB;
            else if (!sr_mif) state_d = S_POLL;
            else if (sr_mal)  state_d = S_FIN;   // controller already left the bus
            else begin
               case (phase_q)
                  PH_ADDR: begin
                     if (sr_rxak || (len_q == 4'd0)) state_d = S_STOP;
                     else if (rw_q)                  state_d = S_RXSET;
                     else                            state_d = S_TXB;
                  end
                  PH_TX: begin
                     if (sr_rxak || (cnt_q == len_q)) state_d = S_STOP;
                     else                             state_d = S_TXB;
                  end
                  default: begin
                     if (last_rx || penult_rx) state_d = S_CHK;
                     else                      state_d = S_RXB;
                  end
               endcase
            end
         end
         S_TXB:     state_d = S_POLL;
         S_RXSET:   state_d = S_RXDUMMY;
         S_RXDUMMY: state_d = S_POLL;
         S_RXB:     state_d = last_rx ? S_FIN : S_POLL;
         S_STOP:    state_d = S_FIN;
         S_FIN:     state_d = S_IDLE;
         default:   state_d = S_INIT_FDR;
      endcase
   end

   // Transaction context
   always_ff @(posedge sysclk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         phase_q   <= PH_ADDR;
         addr_q    <= 7'h00;
         rw_q      <= 1'b0;
         len_q     <= 4'h0;
         cnt_q     <= 4'h0;
         err_q     <= 1'b0;
         gap_q     <= 8'h00;
         chk2_q    <= 1'b0;
         rx_pend_q <= 1'b0;
      end else begin
         rx_pend_q <= (state_q == S_RXB);

         if ((state_q == S_POLL) && !gap_done) gap_q <= gap_q + 8'd1;
         else                                  gap_q <= 8'h00;

         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  addr_q <= cmd_addr_i;
                  rw_q   <= cmd_rw_i;
                  len_q  <= cmd_len_i;
                  cnt_q  <= 4'h0;
                  err_q  <= 1'b0;
               end
            end
            S_ADDR:    phase_q <= PH_ADDR;
            S_TXB: begin
               phase_q <= PH_TX;
               cnt_q   <= cnt_q + 4'd1;
            end
            S_RXDUMMY: phase_q <= PH_RX;
            S_RXB:     cnt_q   <= cnt_q + 4'd1;
            S_CHK: begin
               if (chk2_q) chk2_q <= 1'b0;
               else if (sr_mif) begin
                  if (sr_mal) err_q <= 1'b1;
                  else if ((phase_q != PH_RX) && sr_rxak) err_q <= 1'b1;
                  else if ((phase_q == PH_RX) && (last_rx || penult_rx)) chk2_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output logic
   always_comb begin
      cmd_ready_o = 1'b0;
      tx_req_o    = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      wr_ena_o    = 1'b0;
      wr_addr_o   = 5'h00;
      wr_data_o   = 8'h00;
      rd_ena_o    = 1'b0;
      rd_addr_o   = 5'h00;
      case (state_q)
         S_INIT_FDR: begin
            // Held off while in reset so the FDR write lands on the first edge
            // after release and the port is quiet during reset.
            if (reset_n_i) begin
               wr_ena_o  = 1'b1;
               wr_addr_o = A_FDR;
               wr_data_o = FDR_VAL;
            end
         end
         S_INIT_CR: begin
            wr_ena_o  = 1'b1;
            wr_addr_o = A_CR;
            wr_data_o = CR_IDLE;
         end
         S_IDLE: cmd_ready_o = 1'b1;
         S_START: begin
            wr_ena_o  = 1'b1;
            wr_addr_o = A_CR;
            wr_data_o = CR_START;
         end
         S_ADDR: begin
            wr_ena_o  = 1'b1;
            wr_addr_o = A_DR;
            wr_data_o = {addr_q, rw_q};
         end
         S_POLL: begin
            if (gap_done) begin
               rd_ena_o  = 1'b1;
               rd_addr_o = A_SR;
            end
         end
         S_CHK: begin
            if (chk2_q) begin
               // Last byte: STOP before the DR read; second-to-last: NACK next
               wr_ena_o  = 1'b1;
               wr_addr_o = A_CR;
               wr_data_o = last_rx ? CR_IDLE : CR_RXNAK;
            end else if (sr_mif) begin
               wr_ena_o  = 1'b1;
               wr_addr_o = A_SR;
               wr_data_o = 8'h00;
            end
         end
         S_TXB: begin
            tx_req_o  = 1'b1;
            wr_ena_o  = 1'b1;
            wr_addr_o = A_DR;
            wr_data_o = tx_data_i;
         end
         S_RXSET: begin
            wr_ena_o  = 1'b1;
            wr_addr_o = A_CR;
            wr_data_o = (len_q == 4'd1) ? CR_RXNAK : CR_RX;
         end
         S_RXDUMMY, S_RXB: begin
            rd_ena_o  = 1'b1;
            rd_addr_o = A_DR;
         end
         S_STOP: begin
            wr_ena_o  = 1'b1;
            wr_addr_o = A_CR;
            wr_data_o = CR_IDLE;
         end
         S_FIN: begin
            done_o = 1'b1;
            err_o  = err_q;
         end
         default: ;
      endcase
   end

   assign busy_o     = !((state_q == S_INIT_FDR) || (state_q == S_INIT_CR) ||
                         (state_q == S_IDLE));
   assign rx_valid_o = rx_pend_q;
   assign rx_data_o  = rx_pend_q ? rd_data_i : 8'h00;

endmodule

// File: tb/tb_i2c_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_i2c_xfer_ctrl
// Directed bench: a small register model of the I2C controller plus a scripted
// slave (ACK/NACK per byte, arbitration loss, read data) answers the DUT's
// register port. Register writes and DR reads are logged and compared against
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_i2c_xfer_ctrl;

   logic       clk = 1'b0;
   logic       reset_n_i = 1'b0;
   logic       cmd_valid_i = 1'b0;
   logic       cmd_ready_o;
   logic [6:0] cmd_addr_i = 7'h00;
   logic       cmd_rw_i = 1'b0;
   logic [3:0] cmd_len_i = 4'h0;
   logic [7:0] tx_data_i = 8'h00;
   logic       tx_req_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       done_o, err_o, busy_o;
   logic       wr_ena_o;
   logic [4:0] wr_addr_o;
   logic [7:0] wr_data_o;
   logic       rd_ena_o;
   logic [4:0] rd_addr_o;
   logic [7:0] rd_data_i = 8'h00;

   always #5 clk = ~clk;

   i2c_xfer_ctrl #(.FDR_VAL(8'h07), .POLL_GAP(4)) dut (
      .sysclk_i(clk), .reset_n_i(reset_n_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_addr_i(cmd_addr_i), .cmd_rw_i(cmd_rw_i), .cmd_len_i(cmd_len_i),
      .tx_data_i(tx_data_i), .tx_req_o(tx_req_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o),
      .wr_ena_o(wr_ena_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i)
   );

   int checks = 0;
   int errors = 0;

   // Controller / slave model state
   logic [15:0] log_q[$];
   logic [7:0]  rx_q[$];
   logic [7:0]  tx_bytes [16];
   logic [7:0]  rx_bytes [16];
   logic [7:0]  cr_reg = 8'h00;
   logic [7:0]  sr_reg = 8'h00;
   logic [15:0] nack_mask = 16'h0000;
   int mal_idx = -1;
   int byte_idx = 0;
   int mif_cd = 0;
   int mif_delay = 8;
   int rd_cnt = 0;
   int tx_cnt = 0;
   int tx_idx = 0;
   int done_cnt = 0;
   bit done_seen = 1'b0;
   bit err_cap = 1'b0;
   bit both_seen = 1'b0;

   function automatic logic [15:0] enc_w(input logic [4:0] a, input logic [7:0] d);
      return {1'b1, 2'b00, a, d};
   endfunction

   function automatic logic [15:0] enc_r(input logic [4:0] a);
      return {1'b0, 2'b00, a, 8'h00};
   endfunction

   always @(negedge clk) begin
      if (rx_valid_o) rx_q.push_back(rx_data_o);
      if (done_o) begin
         done_seen = 1'b1;
         done_cnt++;
         err_cap = err_o;
      end
      if (wr_ena_o && rd_ena_o) both_seen = 1'b1;
      if (wr_ena_o) begin
         log_q.push_back(enc_w(wr_addr_o, wr_data_o));
         case (wr_addr_o)
            5'h08: cr_reg = wr_data_o;
            5'h0C: sr_reg = wr_data_o;
            5'h10: mif_cd = mif_delay;
            default: ;
         endcase
      end
      if (tx_req_o) begin
         tx_cnt++;
         tx_idx++;
         tx_data_i = tx_bytes[tx_idx];
      end
      if (rd_ena_o) begin
         if (rd_addr_o == 5'h0C) rd_data_i = sr_reg;
         else if (rd_addr_o == 5'h10) begin
            log_q.push_back(enc_r(5'h10));
            rd_data_i = (rd_cnt == 0) ? 8'hFF : rx_bytes[rd_cnt-1];
            rd_cnt++;
            if (cr_reg[5]) mif_cd = mif_delay;  // still master: clock next byte
         end else rd_data_i = 8'h00;
      end
      if (mif_cd > 0) begin
         mif_cd--;
         if (mif_cd == 0) begin
            sr_reg = 8'h82 | {7'b0, nack_mask[byte_idx]} |
                     ((byte_idx == mal_idx) ? 8'h10 : 8'h00);
            byte_idx++;
         end
      end
   end

   task automatic clear_model();
      log_q.delete();
      rx_q.delete();
      sr_reg = 8'h00;
      nack_mask = 16'h0000;
      mal_idx = -1;
      byte_idx = 0;
      mif_cd = 0;
      rd_cnt = 0;
      tx_cnt = 0;
      tx_idx = 0;
      done_cnt = 0;
      done_seen = 1'b0;
      err_cap = 1'b0;
      tx_data_i = tx_bytes[0];
   endtask

   task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [3:0] len,
                          output bit ok, output bit busy_mid, output bit ready_mid);
      cmd_addr_i = a;
      cmd_rw_i = rw;
      cmd_len_i = len;
      cmd_valid_i = 1'b1;
      @(posedge clk); #2;
      cmd_valid_i = 1'b0;
      @(posedge clk); #2;
      busy_mid = busy_o;
      ready_mid = cmd_ready_o;
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (done_seen) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
   endtask

   task automatic test_reset();
      reset_n_i = 1'b0;
      clear_model();
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if ({cmd_ready_o, busy_o, tx_req_o, rx_valid_o, done_o, err_o, wr_ena_o, rd_ena_o} !== 8'h00 ||
          rx_data_o !== 8'h00 || wr_addr_o !== 5'h00 || wr_data_o !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: ready=%b busy=%b wr=%b rd=%b rx_data=%h wr_addr=%h, all required 0",
                  cmd_ready_o, busy_o, wr_ena_o, rd_ena_o, rx_data_o, wr_addr_o);
      end
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (wr_ena_o !== 1'b1 || wr_addr_o !== 5'h04 || wr_data_o !== 8'h07) begin
         errors++;
         $display("FAIL init_fdr: wr_ena=%b addr=%h data=%h, required 1/04/07", wr_ena_o, wr_addr_o, wr_data_o);
      end
      @(posedge clk); #2;
      checks++;
      if (wr_ena_o !== 1'b1 || wr_addr_o !== 5'h08 || wr_data_o !== 8'h80 || cmd_ready_o !== 1'b0) begin
         errors++;
         $display("FAIL init_cr: wr_ena=%b addr=%h data=%h ready=%b, required 1/08/80/0",
                  wr_ena_o, wr_addr_o, wr_data_o, cmd_ready_o);
      end
      @(posedge clk); #2;
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || wr_ena_o !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready: ready=%b busy=%b wr=%b, required 1/0/0", cmd_ready_o, busy_o, wr_ena_o);
      end
   endtask

   task automatic test_write();
      logic [15:0] exp[$];
      bit ok, bm, rm;
      clear_model();
      tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C; tx_bytes[2] = 8'h00;
      tx_data_i = tx_bytes[0];
      run_cmd(7'h50, 1'b0, 4'd2, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'hA0));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h10, 8'hA5));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h10, 8'h3C));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'h80));
      checks++;
      if (!ok) begin errors++; $display("FAIL write_done: no done_o within budget, required done"); end
      checks++;
      if (bm !== 1'b1 || rm !== 1'b0) begin
         errors++;
         $display("FAIL write_busy: busy=%b ready=%b mid-transaction, required 1/0", bm, rm);
      end
      checks++;
      if (log_q.size() != exp.size()) begin
         errors++;
         $display("FAIL write_seq_len: got %0d accesses, required %0d", log_q.size(), exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL write_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      checks++;
      if (tx_cnt != 2 || err_cap !== 1'b0 || done_cnt != 1) begin
         errors++;
         $display("FAIL write_status: tx_req=%0d err=%b done_pulses=%0d, required 2/0/1", tx_cnt, err_cap, done_cnt);
      end
      checks++;
      if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         errors++;
         $display("FAIL write_after: ready=%b busy=%b, required 1/0", cmd_ready_o, busy_o);
      end
   endtask

   task automatic test_read();
      logic [15:0] exp[$];
      bit ok, bm, rm;
      clear_model();
      rx_bytes[0] = 8'h11; rx_bytes[1] = 8'h22; rx_bytes[2] = 8'h33;
      run_cmd(7'h50, 1'b1, 4'd3, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'hA1));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'hA0));
      exp.push_back(enc_r(5'h10));        exp.push_back(enc_w(5'h0C, 8'h00));
      exp.push_back(enc_r(5'h10));        exp.push_back(enc_w(5'h0C, 8'h00));
      exp.push_back(enc_w(5'h08, 8'hA8)); exp.push_back(enc_r(5'h10));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'h80));
      exp.push_back(enc_r(5'h10));
      checks++;
      if (!ok) begin errors++; $display("FAIL read_done: no done_o within budget, required done"); end
      checks++;
      if (log_q.size() != exp.size()) begin
         errors++;
         $display("FAIL read_seq_len: got %0d accesses, required %0d", log_q.size(), exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL read_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      checks++;
      if (rx_q.size() != 3) begin
         errors++;
         $display("FAIL read_rx_count: got %0d bytes, required 3", rx_q.size());
      end else begin
         checks++;
         if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33) begin
            errors++;
            $display("FAIL read_rx_data: got %h %h %h, required 11 22 33", rx_q[0], rx_q[1], rx_q[2]);
         end
      end
      checks++;
      if (err_cap !== 1'b0 || tx_cnt != 0) begin
         errors++;
         $display("FAIL read_status: err=%b tx_req=%0d, required 0/0", err_cap, tx_cnt);
      end
   endtask

   task automatic test_addr_nack();
      logic [15:0] exp[$];
      bit ok, bm, rm;
      clear_model();
      nack_mask = 16'h0001;
      run_cmd(7'h50, 1'b0, 4'd4, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'hA0));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'h80));
      checks++;
      if (!ok || log_q.size() != exp.size()) begin
         errors++;
         $display("FAIL nack_seq_len: done=%b accesses=%0d, required 1/%0d", ok, log_q.size(), exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL nack_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      checks++;
      if (tx_cnt != 0 || err_cap !== 1'b1) begin
         errors++;
         $display("FAIL nack_status: tx_req=%0d err=%b, required 0/1", tx_cnt, err_cap);
      end
   endtask

   task automatic test_arb_lost();
      logic [15:0] exp[$];
      bit ok, bm, rm;
      clear_model();
      mal_idx = 1;
      tx_bytes[0] = 8'hA5; tx_bytes[1] = 8'h3C;
      tx_data_i = tx_bytes[0];
      run_cmd(7'h50, 1'b0, 4'd2, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'hA0));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h10, 8'hA5));
      exp.push_back(enc_w(5'h0C, 8'h00));
      checks++;
      if (!ok || log_q.size() != exp.size()) begin
         errors++;
         $display("FAIL mal_seq_len: done=%b accesses=%0d, required 1/%0d", ok, log_q.size(), exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL mal_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      checks++;
      if (tx_cnt != 1 || err_cap !== 1'b1) begin
         errors++;
         $display("FAIL mal_status: tx_req=%0d err=%b, required 1/1", tx_cnt, err_cap);
      end
   endtask

   task automatic test_probe_and_read1();
      logic [15:0] exp[$];
      bit ok, bm, rm;
      // Address-only probe right after the arbitration loss
      clear_model();
      run_cmd(7'h3A, 1'b0, 4'd0, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'h74));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'h80));
      checks++;
      if (!ok || log_q.size() != exp.size() || err_cap !== 1'b0 || tx_cnt != 0) begin
         errors++;
         $display("FAIL probe_status: done=%b accesses=%0d err=%b tx=%0d, required 1/4/0/0",
                  ok, log_q.size(), err_cap, tx_cnt);
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL probe_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      // Single-byte read
      exp.delete();
      clear_model();
      rx_bytes[0] = 8'h5A;
      run_cmd(7'h21, 1'b1, 4'd1, ok, bm, rm);
      exp.push_back(enc_w(5'h08, 8'hB0)); exp.push_back(enc_w(5'h10, 8'h43));
      exp.push_back(enc_w(5'h0C, 8'h00)); exp.push_back(enc_w(5'h08, 8'hA8));
      exp.push_back(enc_r(5'h10));        exp.push_back(enc_w(5'h0C, 8'h00));
      exp.push_back(enc_w(5'h08, 8'h80)); exp.push_back(enc_r(5'h10));
      checks++;
      if (!ok || log_q.size() != exp.size()) begin
         errors++;
         $display("FAIL read1_seq_len: done=%b accesses=%0d, required 1/%0d", ok, log_q.size(), exp.size());
      end
      foreach (exp[i]) begin
         checks++;
         if (i >= log_q.size() || log_q[i] !== exp[i]) begin
            errors++;
            $display("FAIL read1_seq[%0d]: got %h, required %h", i,
                     (i < log_q.size()) ? log_q[i] : 16'hxxxx, exp[i]);
         end
      end
      checks++;
      if (rx_q.size() != 1 || err_cap !== 1'b0) begin
         errors++;
         $display("FAIL read1_rx_count: bytes=%0d err=%b, required 1/0", rx_q.size(), err_cap);
      end else begin
         checks++;
         if (rx_q[0] !== 8'h5A) begin
            errors++;
            $display("FAIL read1_rx_data: got %h, required 5a", rx_q[0]);
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [15:0] exp[$];
      bit seen;
      clear_model();
      tx_bytes[0] = 8'h96; tx_bytes[1] = 8'h69;
      tx_data_i = tx_bytes[0];
      cmd_addr_i = 7'h50; cmd_rw_i = 1'b0; cmd_len_i = 4'd2; cmd_valid_i = 1'b1;
      @(posedge clk); #2;
      cmd_valid_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (tx_cnt >= 1) begin
            seen = 1'b1;
            break;
         end
         @(posedge clk); #2;
      end
      checks++;
      if (!seen) begin errors++; $display("FAIL abort_progress: no tx_req_o within budget, required one"); end
      reset_n_i = 1'b0;
      #1;
      checks++;
      if (wr_ena_o !== 1'b0 || rd_ena_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b0 || done_o !== 1'b0) begin
         errors++;
         $display("FAIL abort_outputs: wr=%b rd=%b busy=%b ready=%b done=%b, required all 0",
                  wr_ena_o, rd_ena_o, busy_o, cmd_ready_o, done_o);
      end
      clear_model();
      repeat (2) @(posedge clk);
      #2;
      reset_n_i = 1'b1;
      #1;
      checks++;
      if (wr_ena_o !== 1'b1 || wr_addr_o !== 5'h04 || wr_data_o !== 8'h07) begin
         errors++;
         $display("FAIL abort_reinit: wr_ena=%b addr=%h data=%h, required 1/04/07", wr_ena_o, wr_addr_o, wr_data_o);
      end
      repeat (2) @(posedge clk);
      #2;
      exp.push_back(enc_w(5'h04, 8'h07)); exp.push_back(enc_w(5'h08, 8'h80));
      checks++;
      if (log_q.size() != 2 || log_q[0] !== exp[0] || log_q[1] !== exp[1] || cmd_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL abort_seq: accesses=%0d first=%h ready=%b, required 2/%h/1",
                  log_q.size(), (log_q.size() > 0) ? log_q[0] : 16'hxxxx, cmd_ready_o, exp[0]);
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         tx_bytes[i] = 8'h00;
         rx_bytes[i] = 8'h00;
      end
      test_reset();
      test_write();
      test_read();
      test_addr_nack();
      test_arb_lost();
      test_probe_and_read1();
      test_reset_abort();
      checks++;
      if (both_seen) begin
         errors++;
         $display("FAIL port_exclusive: wr_ena_o and rd_ena_o high together, required never");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_xfer_ctrl.md
I2C_XFER_CTRL -- requirements
Module: i2c_xfer_ctrl

Interface
REQ-001 Parameter: FDR_VAL, default 8'h07, frequency-divider value written once after reset.
REQ-002 Parameter: POLL_GAP, default 4, idle cycles between status-register polls.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-004 sysclk_i  in  1  system clock.
REQ-005 reset_n_i  in  1  asynchronous active-low reset.
REQ-006 cmd_valid_i / cmd_ready_o  in/out  1/1  transaction request handshake; accepted when both are high on a rising edge.
REQ-007 cmd_addr_i  in  7  slave address.
REQ-008 cmd_rw_i  in  1  transfer direction: 1 = read, 0 = write.
REQ-009 cmd_len_i  in  4  data byte count; 0 = address-only probe.
REQ-010 tx_data_i / tx_req_o  in/out  8/1  write byte / one-cycle pulse consuming it; tx_data_i must be valid in the pulse cycle.
REQ-011 rx_data_o / rx_valid_o  out  8/1  received byte / one-cycle valid strobe.
REQ-012 done_o / err_o / busy_o  out  1/1/1  end-of-transaction pulse / error flag (NACK or arbitration loss) qualified by done_o / transaction active.
REQ-013 wr_ena_o, wr_addr_o[4:0], wr_data_o[7:0]  out  controller register write port (i2c_top_module).
REQ-014 rd_ena_o, rd_addr_o[4:0]  out; rd_data_i[7:0]  in  controller register read port; read data is valid one cycle after rd_ena_o.

Function
REQ-015 Register byte addresses: index<<2, with FDR=1, CR=2, SR=3, DR=4.
REQ-016 CR bits: MEN 7, MIEN 6, MSTA 5, MTX 4, TXAK 3, RSTA 2; SR bits: MCF 7, MBB 5, MAL 4, MIF 1, RXAK 0.
REQ-017 At most one register access (read or write) occurs per cycle; wr_ena_o and rd_ena_o are never high together.
REQ-018 States: INIT_FDR, INIT_CR, IDLE, START, ADDR, POLL, CHK, TXB, RXSET, RXDUMMY, RXB, STOP, FIN.
REQ-019 INIT_FDR: write FDR=FDR_VAL; INIT_CR: write CR=8'h80; then enter IDLE. This sequence runs once after reset only.
REQ-020 IDLE: cmd_ready_o=1; on acceptance, latch addr, rw and len, set busy_o, and zero the byte counter.
REQ-021 START: write CR=8'hB0 (MEN|MSTA|MTX); ADDR: write DR={addr,rw}; then enter POLL.
REQ-022 POLL: after POLL_GAP idle cycles, read SR; CHK evaluates the returned value; if MIF=0, return to POLL.
REQ-023 CHK with MIF=1: write SR=8'h00 to clear MIF; if MAL=1, set the error flag and enter FIN without STOP (the controller has already released the bus).
REQ-024 After the address phase: RXAK=1 -> error and STOP; len=0 -> STOP; rw=0 -> TXB; rw=1 -> RXSET.
REQ-025 TXB: pulse tx_req_o and write DR=tx_data_i in the same cycle; increment the counter; POLL; in CHK, RXAK=1 -> error and STOP; counter==len -> STOP; else TXB.
REQ-026 RXSET: write CR=8'hA0 (receive), or 8'hA8 (TXAK) if len==1; RXDUMMY: read DR and discard the data; then POLL.
REQ-027 Read CHK: if the byte is the last one, write CR=8'h80 (STOP) before reading DR; if it is second-to-last, write CR=8'hA8; RXB reads DR; next cycle drives rx_data_o=rd_data_i with rx_valid_o=1 and increments the counter.
REQ-028 RXB loop: counter<len -> POLL; counter==len -> FIN (STOP already issued).
REQ-029 STOP: write CR=8'h80.
REQ-030 FIN: done_o=1 for one cycle, err_o valid in the same cycle; clear busy_o; return to IDLE.
REQ-031 cmd_* inputs are ignored outside IDLE; no queueing.
REQ-032 The counter is 4 bits; len=15 requires no wrap.

Reset
REQ-033 Async assert: all outputs 0 (cmd_ready_o=0, busy_o=0, all strobes 0, rx_data_o=8'h00), state=INIT_FDR, counter and latches cleared.
REQ-034 Reset mid-transaction aborts without issuing STOP and reruns INIT; the controller is reset by the same reset_n_i.
REQ-035 Deassertion: the first register write (FDR) occurs on the first rising edge after reset_n_i goes high.

Verification (bench: controller register model plus I2C slave model)
REQ-036 Reset release -> wr(FDR addr 5'h04, 8'h07), then wr(CR 5'h08, 8'h80); cmd_ready_o=1 on the following cycle.
REQ-037 Write addr 7'h50, len 2, bytes A5/3C, slave ACKs all -> DR writes 8'hA0, A5, 3C; two tx_req_o pulses; CR=8'h80; done_o=1, err_o=0.
REQ-038 Read addr 7'h50, len 3, slave returns 11/22/33 -> DR write 8'hA1; CR=8'hA0, dummy read, CR=8'hA8 before byte 2, CR=8'h80 before byte 3; rx 11,22,33; err_o=0.
REQ-039 Address NACK (RXAK=1) on len 4 write -> no tx_req_o; CR=8'h80; done_o with err_o=1.
REQ-040 MAL=1 during byte 1 -> no STOP write; done_o with err_o=1; next command accepted normally.
REQ-041 len=0 probe and len=1 read -> probe: START, ADDR, STOP only; len=1 read: RXSET writes 8'hA8 and CR=8'h80 precedes the single DR read.
